countnox_ctrl: RTL and testbench
================================

Name: countnox_ctrl

Overview:
Control FSM that drives the load/inc/dec command interface of two 8-bit up/down counters: `i` is the index and `tr` is the tally. It scans a synchronous-read memory of N words from address N-1 down to 0 and counts how many words equal X. It issues all counter commands, observes both counter values, and returns the final tally with a one-cycle done pulse. It sits between the top-level start/result handshake and the i/tr counter instances.

Parameters:
SIZE, 8, width of data words, counter values, n_words and result.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous active-high reset
start  in  1  request a scan; sampled only in IDLE
x_value  in  SIZE  value to match; captured when start is accepted
n_words  in  SIZE  number of words N (0..255); captured when start is accepted
mem_rdata  in  SIZE  memory read data; valid the cycle after mem_ren with address = i_count
mem_ren  out  1  memory read enable; memory address is i_count
i_count  in  SIZE  current value of the i counter
tr_count  in  SIZE  current value of the tr counter
i_load  out  1  load i with i_load_value
i_inc  out  1  increment i (never asserted by this block; tied 0)
i_dec  out  1  decrement i
i_load_value  out  SIZE  load value for i
tr_load  out  1  load tr with tr_load_value
tr_inc  out  1  increment tr
tr_dec  out  1  decrement tr (tied 0)
tr_load_value  out  SIZE  load value for tr (constant 0)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle registered pulse; result valid in the same cycle
result  out  SIZE  final tally; registered; held until the next done or reset

Behaviour:
- States: IDLE, INIT, READ, CMP, FIN. Registered state. Counter command outputs and mem_ren are decoded combinationally from state, plus mem_rdata in CMP.
- Reset, synchronous: state=IDLE, done=0, result=0, captured x/N=0. All command outputs are 0 while in IDLE.
- The counters have no reset. The block never relies on their contents before INIT.
- IDLE:
  - start=1: capture x_value and n_words, then go to INIT.
  - Otherwise stay in IDLE.
- INIT:
  - tr_load=1 with tr_load_value=0.
  - If N!=0: i_load=1 with i_load_value=N-1, then go to READ.
  - If N==0: i_load=0, then go to FIN.
- READ: mem_ren=1 (address = i_count). Go to CMP.
- CMP: compare mem_rdata with captured x.
  - Equal: tr_inc=1.
  - i_count==0: go to FIN.
  - Otherwise: i_dec=1, then go to READ.
- FIN: result<=tr_count (the last increment has already landed), done<=1, go to IDLE.
- done is high exactly one cycle, the first IDLE cycle after FIN.
- Timing: if start is sampled at edge e0, done rises at edge e0+2N+2. Examples: N=0 gives e0+2; N=4 gives e0+10.
- Per counter, at most one of load/inc/dec is high in any cycle.
- tr increments at most once per word. For N<=255, tr never wraps and result<=N.
- i never decrements below 0; exit is decided on i_count==0 before any i_dec.
- start while busy: ignored, with no effect on the scan or on the captured x/N.
- start high in the same cycle that done is high: accepted, so a new scan begins immediately. result keeps the old value until the next done.
- x_value/n_words changing mid-scan: no effect.
- reset mid-scan: aborts immediately to IDLE with all outputs 0. A later start performs a complete, correct scan.

Test Plan:
- Reset, then idle for 5 cycles -> busy=0, done=0, result=0, mem_ren=0, all counter commands 0.
- N=4, mem[3..0]={5,5,3,5} (addr 3 first), X=5, start one cycle -> mem_ren addresses 3,2,1,0; tr_inc 3 times; done at e0+10; result=3.
- N=0, X=7, start -> tr_load once, no i_load, no mem_ren; done at e0+2; result=0.
- N=255, all words=0xAA, X=0xAA -> result=255 with no wrap; done at e0+512; i_dec asserted 254 times.
- Start re-pulsed during a scan, and x_value/n_words changed mid-scan -> the original scan completes unchanged, with exactly one done.
- Reset asserted mid-scan (N=4, after 2 words) -> next cycle busy=0, result=0. Restart with {1,2,1,1}, X=1 -> result=3.

Source files
------------

// File: rtl/countnox_ctrl.sv
// countnox_ctrl: scans N memory words from N-1 down to 0 and tallies those equal to X using external i/tr counters
module countnox_ctrl #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [SIZE-1:0] x_value,
  input  logic [SIZE-1:0] n_words,
  input  logic [SIZE-1:0] mem_rdata,
  output logic            mem_ren,
  input  logic [SIZE-1:0] i_count,
  input  logic [SIZE-1:0] tr_count,
  output logic            i_load,
  output logic            i_inc,
  output logic            i_dec,
  output logic [SIZE-1:0] i_load_value,
  output logic            tr_load,
  output logic            tr_inc,
  output logic            tr_dec,
  output logic [SIZE-1:0] tr_load_value,
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] result
);
  typedef enum logic [2:0] {IDLE, INIT, READ, CMP, FIN} state_t;
  state_t state_q, state_d;
  logic [SIZE-1:0] x_q, x_d, n_q, n_d, result_q, result_d;
  logic done_q, done_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      x_q      <= '0;
      n_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      n_q      <= n_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    n_d          = n_q;
    result_d     = result_q;
    done_d       = 1'b0;
    mem_ren      = 1'b0;
    i_load       = 1'b0;
    i_dec        = 1'b0;
    i_load_value = '0;
    tr_load      = 1'b0;
    tr_inc       = 1'b0;
    case (state_q)
      IDLE: begin
        x_d     = start ? x_value : x_q;
        n_d     = start ? n_words : n_q;
        state_d = start ? INIT : IDLE;
      end
      INIT: begin
        tr_load      = 1'b1;
        i_load       = n_q != '0;
        i_load_value = n_q - SIZE'(1);
        state_d      = (n_q != '0) ? READ : FIN;
      end
      READ: begin
        mem_ren = 1'b1;
        state_d = CMP;
      end
      CMP: begin
        tr_inc  = mem_rdata == x_q;
        i_dec   = i_count != '0;
        state_d = (i_count == '0) ? FIN : READ;
      end
      FIN: begin
        result_d = tr_count;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign i_inc         = 1'b0;
  assign tr_dec        = 1'b0;
  assign tr_load_value = '0;
  assign busy          = state_q != IDLE;
  assign done          = done_q;
  assign result        = result_q;
endmodule

// File: tb/tb_countnox_ctrl.sv
// tb_countnox_ctrl: scoreboard bench with counter/memory models around countnox_ctrl
module tb_countnox_ctrl;
  logic clk, reset, start;
  logic [7:0] x_value, n_words, mem_rdata, i_count, tr_count, i_load_value, tr_load_value, result;
  logic mem_ren, i_load, i_inc, i_dec, tr_load, tr_inc, tr_dec, busy, done;
  logic [7:0] mem [256];
  typedef struct {int res; int at; int dec; int inc; int iload;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  int addr_q[$];
  int cyc = 0, free_at = 0, busy_from = 0;
  int n_cmp = 0, n_bad = 0;
  int n_dec = 0, n_inc = 0, n_iload = 0, n_trload = 0, last_res = 0;
  countnox_ctrl #(.SIZE(8)) dut (
    .clk(clk), .reset(reset), .start(start), .x_value(x_value), .n_words(n_words),
    .mem_rdata(mem_rdata), .mem_ren(mem_ren), .i_count(i_count), .tr_count(tr_count),
    .i_load(i_load), .i_inc(i_inc), .i_dec(i_dec), .i_load_value(i_load_value),
    .tr_load(tr_load), .tr_inc(tr_inc), .tr_dec(tr_dec), .tr_load_value(tr_load_value),
    .busy(busy), .done(done), .result(result)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (i_load) i_count <= i_load_value;
    else if (i_inc) i_count <= i_count + 8'd1;
    else if (i_dec) i_count <= i_count - 8'd1;
    if (tr_load) tr_count <= tr_load_value;
    else if (tr_inc) tr_count <= tr_count + 8'd1;
    else if (tr_dec) tr_count <= tr_count - 8'd1;
    if (mem_ren) mem_rdata <= mem[i_count];
  end
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (reset) begin
      n_dec = 0; n_inc = 0; n_iload = 0; n_trload = 0; last_res = 0;
    end else begin
      chk("busy", int'(busy), int'(cyc >= busy_from && cyc < free_at - 1));
      chk("i_cmd_onehot", int'($countones({i_load, i_inc, i_dec}) <= 1), 1);
      chk("tr_cmd_onehot", int'($countones({tr_load, tr_inc, tr_dec}) <= 1), 1);
      chk("tied_outputs", int'({i_inc, tr_dec, tr_load_value}), 0);
      if (mem_ren) begin
        chk("mem_ren_expected", int'(addr_q.size() != 0), 1);
        if (addr_q.size() != 0) chk("mem_addr", int'(i_count), addr_q.pop_front());
      end
      if (done) begin
        chk("done_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("result", int'(result), e.res);
          chk("done_cycle", cyc, e.at);
          chk("i_dec_count", n_dec, e.dec);
          chk("tr_inc_count", n_inc, e.inc);
          chk("i_load_count", n_iload, e.iload);
          chk("tr_load_count", n_trload, 1);
          last_res = e.res;
        end
        n_dec = 0; n_inc = 0; n_iload = 0; n_trload = 0;
      end else chk("result_hold", int'(result), last_res);
      n_dec += int'(i_dec);
      n_inc += int'(tr_inc);
      n_iload += int'(i_load);
      n_trload += int'(tr_load);
    end
  end
  task automatic drive(input logic st, input logic [7:0] xv, input logic [7:0] nv);
    int n, m, ev;
    start = st; x_value = xv; n_words = nv;
    n = int'(nv);
    ev = cyc + 1;
    if (st && !reset && ev >= free_at) begin
      m = 0;
      for (int a = 0; a < n; a++) if (mem[a] == xv) m++;
      for (int a = n - 1; a >= 0; a--) addr_q.push_back(a);
      exp_q.push_back('{res: m, at: ev + 2 * n + 2, dec: (n > 0) ? n - 1 : 0, inc: m, iload: int'(n > 0)});
      busy_from = ev;
      free_at = ev + 2 * n + 3;
    end
    @(posedge clk); #1;
  endtask
  task automatic do_reset(input int k);
    reset = 1; start = 0;
    exp_q.delete(); addr_q.delete();
    free_at = 0; busy_from = 0;
    repeat (k) begin @(posedge clk); #1; end
    reset = 0;
  endtask
  task automatic wait_idle();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 1000) begin
      drive(0, x_value, n_words);
      k++;
    end
    chk("scan_finishes", exp_q.size(), 0);
  endtask
  task automatic load4(input logic [7:0] a3, input logic [7:0] a2, input logic [7:0] a1, input logic [7:0] a0);
    mem[3] = a3; mem[2] = a2; mem[1] = a1; mem[0] = a0;
  endtask
  initial begin
    start = 0; x_value = 0; n_words = 0;
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    do_reset(2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("idle_busy", int'(busy), 0);
      chk("idle_done", int'(done), 0);
      chk("idle_result", int'(result), 0);
      chk("idle_cmds", int'({mem_ren, i_load, i_inc, i_dec, tr_load, tr_inc, tr_dec}), 0);
      @(posedge clk); #1;
    end
    load4(5, 5, 3, 5);
    drive(1, 5, 4);
    wait_idle();
    chk("n4_result", int'(result), 3);
    drive(1, 7, 0);
    wait_idle();
    chk("n0_result", int'(result), 0);
    for (int a = 0; a < 256; a++) mem[a] = 8'hAA;
    drive(1, 8'hAA, 8'd255);
    wait_idle();
    chk("n255_result", int'(result), 255);
    load4(5, 5, 3, 5);
    drive(1, 5, 4);
    drive(0, 5, 4);
    drive(1, 3, 9);
    drive(1, 3, 9);
    drive(0, 8'h77, 8'h20);
    drive(1, 8'hAA, 8'd200);
    wait_idle();
    chk("repulse_result", int'(result), 3);
    drive(1, 5, 4);
    repeat (4) drive(0, 5, 4);
    do_reset(1);
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_result", int'(result), 0);
    @(posedge clk); #1;
    load4(1, 2, 1, 1);
    drive(1, 1, 4);
    wait_idle();
    chk("restart_result", int'(result), 3);
    for (int a = 0; a < 32; a++) mem[a] = 8'($urandom_range(0, 3));
    for (int k = 0; k < 600; k++)
      drive($urandom_range(0, 2) == 0, 8'($urandom_range(0, 3)), 8'($urandom_range(0, 12)));
    drive(0, 0, 0);
    wait_idle();
    chk("addr_queue_drained", addr_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
